// File: rtl/write_req_xbar_nm_pkg.sv
// Shared write-path types for the vector cache write-request crossbar.
// Consumers import vector_cache_pkg::*.
package vector_cache_pkg;

  localparam int unsigned ADDR_WIDTH          = 64;
  localparam int unsigned TXNID_WIDTH         = 8;
  localparam int unsigned SIDEBAND_WIDTH      = 8;
  localparam int unsigned DATA_WIDTH          = 128;
  localparam int unsigned STRB_WIDTH          = DATA_WIDTH / 8;
  localparam int unsigned DB_ENTRY_IDX_WIDTH  = 6;
  localparam int unsigned ROB_ENTRY_IDX_WIDTH = 6;

  typedef enum logic [1:0] {
    CMD_READ  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_EVICT = 2'd2,
    CMD_NOP   = 2'd3
  } cmd_opcode_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     addr;
    logic [TXNID_WIDTH-1:0]    txnid;
    logic [SIDEBAND_WIDTH-1:0] sideband;
    logic [STRB_WIDTH-1:0]     strb;
    logic [DATA_WIDTH-1:0]     data;
  } input_write_cmd_pld_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]          addr;
    logic [TXNID_WIDTH-1:0]         txnid;
    logic [SIDEBAND_WIDTH-1:0]      sideband;
    cmd_opcode_e                    cmd_opcode;
    logic [DB_ENTRY_IDX_WIDTH-1:0]  db_entry_id;
    logic [ROB_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
  } input_req_pld_t;

  typedef struct packed {
    input_req_pld_t                cmd;
    logic [DB_ENTRY_IDX_WIDTH-1:0] db_entry_id;
    logic [STRB_WIDTH-1:0]         strb;
    logic [DATA_WIDTH-1:0]         data;
  } wdb_pld_t;

  typedef struct packed {
    input_req_pld_t        cmd;
    logic [STRB_WIDTH-1:0] strb;
    logic [DATA_WIDTH-1:0] data;
  } wr_lane_entry_t;

  function automatic wr_lane_entry_t mk_lane_entry(input input_write_cmd_pld_t c,
                                                   input logic [DB_ENTRY_IDX_WIDTH-1:0] idx);
    wr_lane_entry_t e;
    e.cmd.addr         = c.addr;
    e.cmd.txnid        = c.txnid;
    e.cmd.sideband     = c.sideband;
    e.cmd.cmd_opcode   = CMD_WRITE;
    e.cmd.db_entry_id  = idx;
    e.cmd.rob_entry_id = '0;
    e.strb             = c.strb;
    e.data             = c.data;
    return e;
  endfunction

  function automatic wdb_pld_t mk_wdb(input wr_lane_entry_t e);
    wdb_pld_t w;
    w.cmd         = e.cmd;
    w.db_entry_id = e.cmd.db_entry_id;
    w.strb        = e.strb;
    w.data        = e.data;
    return w;
  endfunction

endpackage

// File: rtl/write_req_xbar_nm_if.sv
// Handshake bundle of the write-request crossbar: command ingress, DB
// allocation and per-lane output. slave = crossbar side.
interface write_req_xbar_nm_if
  import vector_cache_pkg::*;
#(
  parameter int unsigned W_REQ_NUM = 8,
  parameter int unsigned OUT_NUM   = 4
);

  logic [W_REQ_NUM-1:0]          wr_cmd_vld;
  input_write_cmd_pld_t          wr_cmd_pld [W_REQ_NUM];
  logic [W_REQ_NUM-1:0]          wr_cmd_rdy;
  logic [OUT_NUM-1:0]            alloc_vld;
  logic [DB_ENTRY_IDX_WIDTH-1:0] alloc_idx [OUT_NUM];
  logic [OUT_NUM-1:0]            alloc_rdy;
  logic [OUT_NUM-1:0]            sel_wr_vld;
  input_req_pld_t                sel_wr_pld [OUT_NUM];
  wdb_pld_t                      sel_wr_data_pld [OUT_NUM];
  logic [OUT_NUM-1:0]            sel_wr_rdy;

  modport master (
    output wr_cmd_vld, wr_cmd_pld, alloc_vld, alloc_idx, sel_wr_rdy,
    input  wr_cmd_rdy, alloc_rdy, sel_wr_vld, sel_wr_pld, sel_wr_data_pld
  );

  modport slave (
    input  wr_cmd_vld, wr_cmd_pld, alloc_vld, alloc_idx, sel_wr_rdy,
    output wr_cmd_rdy, alloc_rdy, sel_wr_vld, sel_wr_pld, sel_wr_data_pld
  );

endinterface

// File: rtl/write_req_xbar_nm_skid.sv
// wr_lane_skid2: 2-entry in-order valid/ready buffer; count exposed so the
// producer can gate on occupancy without a ready-to-ready path.
module wr_lane_skid2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_rdy,
  output logic             vld,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [1:0]       cnt;
  logic             pop;

  assign vld   = (cnt != 2'd0);
  assign pop   = vld && pop_rdy;
  assign data  = slot0;
  assign count = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (push && !pop) begin
      cnt <= cnt + 2'd1;
    end else if (pop && !push) begin
      cnt <= cnt - 2'd1;
    end
  end

  // Payload is never reset; slot0 is always the head.
  always_ff @(posedge clk) begin
    if (pop) begin
      slot0 <= (cnt == 2'd2) ? slot1 : push_data;
      if (push && (cnt == 2'd2)) begin
        slot1 <= push_data;
      end
    end else if (push) begin
      if (cnt == 2'd0) begin
        slot0 <= push_data;
      end else begin
        slot1 <= push_data;
      end
    end
  end

endmodule

// File: rtl/write_req_xbar_nm.sv
// N-to-M write-request crossbar: address-selected lanes, per-lane round-robin
// with DB allocation handshake, 2-entry skid per lane. Option: WR_XBAR_PERF_CNT_EN.
module write_req_xbar_nm
  import vector_cache_pkg::*;
#(
  parameter int unsigned W_REQ_NUM = 8,
  parameter int unsigned OUT_NUM   = 4,
  parameter int unsigned SEL_MSB   = 63
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef WR_XBAR_PERF_CNT_EN
  output logic [31:0]        perf_grant_cnt [OUT_NUM],
  output logic [31:0]        perf_stall_cnt [OUT_NUM],
`endif
  write_req_xbar_nm_if.slave bus
);

  localparam int unsigned SEL_W   = $clog2(OUT_NUM);
  localparam int unsigned PTR_W   = (W_REQ_NUM > 1) ? $clog2(W_REQ_NUM) : 1;
  localparam int unsigned ENTRY_W = $bits(wr_lane_entry_t);

  logic [W_REQ_NUM-1:0] req [OUT_NUM];
  logic [OUT_NUM-1:0]   grant;
  logic [PTR_W-1:0]     gnt_idx [OUT_NUM];
  logic [PTR_W-1:0]     ptr [OUT_NUM];
  logic [1:0]           lane_cnt [OUT_NUM];
  wr_lane_entry_t       push_entry [OUT_NUM];
  wr_lane_entry_t       head_entry [OUT_NUM];
  logic [W_REQ_NUM-1:0] cmd_rdy;

  // Eligibility uses the pre-pop count so sel_wr_rdy never reaches wr_cmd_rdy;
  // rst_n gating keeps both ready outputs low throughout reset.
  always_comb begin
    int unsigned cand;
    logic        found;
    cand    = 0;
    found   = 1'b0;
    cmd_rdy = '0;
    for (int unsigned o = 0; o < OUT_NUM; o++) begin
      req[o]     = '0;
      gnt_idx[o] = '0;
      found      = 1'b0;
      for (int unsigned i = 0; i < W_REQ_NUM; i++) begin
        req[o][i] = bus.wr_cmd_vld[i] &&
                    (bus.wr_cmd_pld[i].addr[SEL_MSB -: SEL_W] == SEL_W'(o));
      end
      for (int unsigned k = 0; k < W_REQ_NUM; k++) begin
        cand = 32'(ptr[o]) + k;
        if (cand >= W_REQ_NUM) begin
          cand = cand - W_REQ_NUM;
        end
        if (!found && req[o][cand]) begin
          found      = 1'b1;
          gnt_idx[o] = PTR_W'(cand);
        end
      end
      grant[o]      = found && rst_n && bus.alloc_vld[o] && (lane_cnt[o] != 2'd2);
      push_entry[o] = mk_lane_entry(bus.wr_cmd_pld[gnt_idx[o]], bus.alloc_idx[o]);
      if (grant[o]) begin
        cmd_rdy[gnt_idx[o]] = 1'b1;
      end
    end
  end

  assign bus.wr_cmd_rdy = cmd_rdy;
  assign bus.alloc_rdy  = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned o = 0; o < OUT_NUM; o++) begin
        ptr[o] <= '0;
      end
    end else begin
      for (int unsigned o = 0; o < OUT_NUM; o++) begin
        if (grant[o]) begin
          ptr[o] <= (gnt_idx[o] == PTR_W'(W_REQ_NUM - 1)) ? '0 : gnt_idx[o] + PTR_W'(1);
        end
      end
    end
  end

  for (genvar o = 0; o < OUT_NUM; o++) begin : g_lane
    wr_lane_skid2 #(
      .WIDTH(ENTRY_W)
    ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (grant[o]),
      .push_data (push_entry[o]),
      .pop_rdy   (bus.sel_wr_rdy[o]),
      .vld       (bus.sel_wr_vld[o]),
      .data      (head_entry[o]),
      .count     (lane_cnt[o])
    );

    assign bus.sel_wr_pld[o]      = head_entry[o].cmd;
    assign bus.sel_wr_data_pld[o] = mk_wdb(head_entry[o]);
  end

`ifdef WR_XBAR_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned o = 0; o < OUT_NUM; o++) begin
        perf_grant_cnt[o] <= '0;
        perf_stall_cnt[o] <= '0;
      end
    end else begin
      for (int unsigned o = 0; o < OUT_NUM; o++) begin
        if (grant[o] && (perf_grant_cnt[o] != '1)) begin
          perf_grant_cnt[o] <= perf_grant_cnt[o] + 32'd1;
        end
        if ((|req[o]) && !grant[o] && (perf_stall_cnt[o] != '1)) begin
          perf_stall_cnt[o] <= perf_stall_cnt[o] + 32'd1;
        end
      end
    end
  end
`endif

endmodule
